// File: rtl/audio_mix_sched.sv
`default_nettype none
// ============================================================================
// Module      : audio_mix_sched
// Description : Time-multiplexed audio mixer. Sums CHANNELS signed sources
//               through one shared multiply-accumulate, one channel per clock,
//               then floors, saturates and registers the mixed sample.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_mix_sched #(
    parameter int AUDIO_DW = 16,
    parameter int CHANNELS = 4,
    parameter int VOL_W    = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sample_stb,
    input  logic [CHANNELS*AUDIO_DW-1:0] ch_data,
    input  logic [CHANNELS*VOL_W-1:0]    ch_vol,
    input  logic [CHANNELS-1:0]          ch_mute,
    output logic [AUDIO_DW-1:0]          mix_out,
    output logic                         mix_valid,
    output logic                         busy,
    output logic                         overrun,
    output logic [7:0]                   overrun_cnt
);

    localparam int c_IDX_W  = $clog2(CHANNELS);
    localparam int c_PROD_W = AUDIO_DW + VOL_W + 1;
    localparam int c_ACC_W  = c_PROD_W + c_IDX_W;
    localparam int c_FRAC_W = VOL_W - 1;

    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(CHANNELS - 1);

    localparam logic signed [c_ACC_W-1:0] c_SAT_MAX =
        {{(c_ACC_W-AUDIO_DW+1){1'b0}}, {(AUDIO_DW-1){1'b1}}};
    localparam logic signed [c_ACC_W-1:0] c_SAT_MIN =
        {{(c_ACC_W-AUDIO_DW+1){1'b1}}, {(AUDIO_DW-1){1'b0}}};

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ACCUM = 2'd1;
    localparam logic [1:0] c_ST_SAT   = 2'd2;

    logic [1:0]                   state_q,     state_d;
    logic [c_IDX_W-1:0]           idx_q,       idx_d;
    logic signed [c_ACC_W-1:0]    acc_q,       acc_d;
    logic [CHANNELS*AUDIO_DW-1:0] data_q,      data_d;
    logic [CHANNELS*VOL_W-1:0]    vol_q,       vol_d;
    logic [CHANNELS-1:0]          mute_q,      mute_d;
    logic [AUDIO_DW-1:0]          mix_out_q,   mix_out_d;
    logic                         mix_valid_q, mix_valid_d;
    logic                         drop_q,      drop_d;
    logic                         overrun_q,   overrun_d;
    logic [7:0]                   ovr_cnt_q,   ovr_cnt_d;

    logic                         w_accept;
    logic [AUDIO_DW-1:0]          w_sel_data;
    logic [VOL_W-1:0]             w_sel_vol;
    logic                         w_sel_mute;
    logic signed [c_PROD_W-1:0]   w_raw_prod;
    logic [c_PROD_W-1:0]          w_prod;
    logic signed [c_ACC_W-1:0]    w_prod_ext;
    logic signed [c_ACC_W-1:0]    w_shifted;
    logic signed [c_ACC_W-1:0]    w_clamped;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE:  if (sample_stb) state_d = c_ST_ACCUM;
            c_ST_ACCUM: if (idx_q == c_LAST_IDX) state_d = c_ST_SAT;
            c_ST_SAT:   state_d = c_ST_IDLE;
            default:    state_d = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy     = (state_q != c_ST_IDLE);
        w_accept = (state_q == c_ST_IDLE) && sample_stb;
        drop_d   = (state_q != c_ST_IDLE) && sample_stb;
    end

    // Channel select from the snapshot taken when the strobe was accepted
    always_comb begin
        w_sel_data = '0;
        w_sel_vol  = '0;
        w_sel_mute = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (idx_q == c_IDX_W'(k)) begin
                w_sel_data = data_q[k*AUDIO_DW +: AUDIO_DW];
                w_sel_vol  = vol_q[k*VOL_W +: VOL_W];
                w_sel_mute = mute_q[k];
            end
        end
    end

    // Gain is unsigned, so it gets a zero sign bit before the signed multiply
    always_comb begin
        w_raw_prod = $signed(w_sel_data) * $signed({1'b0, w_sel_vol});
        w_prod     = w_sel_mute ? '0 : w_raw_prod;
        w_prod_ext = {{c_IDX_W{w_prod[c_PROD_W-1]}}, w_prod};
    end

    // Arithmetic shift floors toward minus infinity before clamping
    always_comb begin
        w_shifted = acc_q >>> c_FRAC_W;
        if (w_shifted > c_SAT_MAX) begin
            w_clamped = c_SAT_MAX;
        end else if (w_shifted < c_SAT_MIN) begin
            w_clamped = c_SAT_MIN;
        end else begin
            w_clamped = w_shifted;
        end
    end

    always_comb begin
        data_d      = data_q;
        vol_d       = vol_q;
        mute_d      = mute_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        mix_out_d   = mix_out_q;
        mix_valid_d = 1'b0;

        if (w_accept) begin
            data_d = ch_data;
            vol_d  = ch_vol;
            mute_d = ch_mute;
            acc_d  = '0;
            idx_d  = '0;
        end

        if (state_q == c_ST_ACCUM) begin
            acc_d = acc_q + w_prod_ext;
            idx_d = (idx_q == c_LAST_IDX) ? '0 : idx_q + 1'b1;
        end

        if (state_q == c_ST_SAT) begin
            mix_out_d   = w_clamped[AUDIO_DW-1:0];
            mix_valid_d = 1'b1;
        end
    end

    // A dropped strobe is flagged one cycle after it is seen
    always_comb begin
        overrun_d = drop_q;
        ovr_cnt_d = ovr_cnt_q;
        if (drop_q && (ovr_cnt_q != 8'hFF)) begin
            ovr_cnt_d = ovr_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q       <= '0;
            acc_q       <= '0;
            data_q      <= '0;
            vol_q       <= '0;
            mute_q      <= '0;
            mix_out_q   <= '0;
            mix_valid_q <= 1'b0;
            drop_q      <= 1'b0;
            overrun_q   <= 1'b0;
            ovr_cnt_q   <= 8'd0;
        end else begin
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            data_q      <= data_d;
            vol_q       <= vol_d;
            mute_q      <= mute_d;
            mix_out_q   <= mix_out_d;
            mix_valid_q <= mix_valid_d;
            drop_q      <= drop_d;
            overrun_q   <= overrun_d;
            ovr_cnt_q   <= ovr_cnt_d;
        end
    end

    assign mix_out     = mix_out_q;
    assign mix_valid   = mix_valid_q;
    assign overrun     = overrun_q;
    assign overrun_cnt = ovr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_mix_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_mix_sched
// Description : Self-checking bench for audio_mix_sched with an arithmetic
//               reference model of the mix.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_mix_sched;

    localparam int DW = 16;
    localparam int CH = 4;
    localparam int VW = 8;

    logic             clk        = 1'b0;
    logic             reset      = 1'b0;
    logic             sample_stb = 1'b0;
    logic [CH*DW-1:0] ch_data    = '0;
    logic [CH*VW-1:0] ch_vol     = '0;
    logic [CH-1:0]    ch_mute    = '0;
    logic [DW-1:0]    mix_out;
    logic             mix_valid;
    logic             busy;
    logic             overrun;
    logic [7:0]       overrun_cnt;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] last_mix;
    logic [DW-1:0] held_exp;

    always #5 clk = ~clk;

    audio_mix_sched #(
        .AUDIO_DW (DW),
        .CHANNELS (CH),
        .VOL_W    (VW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_stb  (sample_stb),
        .ch_data     (ch_data),
        .ch_vol      (ch_vol),
        .ch_mute     (ch_mute),
        .mix_out     (mix_out),
        .mix_valid   (mix_valid),
        .busy        (busy),
        .overrun     (overrun),
        .overrun_cnt (overrun_cnt)
    );

    // Reference: exact integer sum, floor division by 128, clamp to DW bits
    function automatic logic [DW-1:0] model(input logic [CH*DW-1:0] d,
                                            input logic [CH*VW-1:0] v,
                                            input logic [CH-1:0]    m);
        longint        sum;
        longint        q;
        logic [DW-1:0] s;
        logic [VW-1:0] g;
        sum = 0;
        for (int k = 0; k < CH; k++) begin
            if (!m[k]) begin
                s   = d[k*DW +: DW];
                g   = v[k*VW +: VW];
                sum = sum + longint'($signed(s)) * longint'(g);
            end
        end
        q = sum / 128;
        if (sum < 0 && (sum % 128) != 0) q = q - 1;
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return q[DW-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One strobe, then cycle-by-cycle checks of busy, mix_valid and mix_out
    task automatic run_mix(input string tag, input logic [CH*DW-1:0] d,
                           input logic [CH*VW-1:0] v, input logic [CH-1:0] m,
                           input bit chg, input logic [DW-1:0] exp);
        ch_data    = d;
        ch_vol     = v;
        ch_mute    = m;
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        for (int k = 0; k <= CH + 2; k++) begin
            if (k == 0 && chg) begin
                ch_data = {$urandom, $urandom};
                ch_vol  = $urandom;
                ch_mute = 4'($urandom);
            end
            check({tag, "_busy"},  32'(busy),      32'(k <= CH));
            check({tag, "_valid"}, 32'(mix_valid), 32'(k == CH + 1));
            check({tag, "_out"},   32'(mix_out),   32'((k > CH) ? exp : last_mix));
            tick();
        end
        last_mix = exp;
    endtask

    initial begin
        logic [CH*DW-1:0] d;
        logic [CH*VW-1:0] v;
        logic [CH-1:0]    m;

        last_mix = '0;

        // Asynchronous reset with strobes held during reset
        #2;
        reset      = 1'b1;
        sample_stb = 1'b1;
        #1;
        check("rst_async_out",   32'(mix_out),     32'h0);
        check("rst_async_busy",  32'(busy),        32'h0);
        check("rst_async_cnt",   32'(overrun_cnt), 32'h0);
        repeat (3) tick();
        check("rst_hold_valid",  32'(mix_valid),   32'h0);
        check("rst_hold_busy",   32'(busy),        32'h0);
        check("rst_hold_ovr",    32'(overrun),     32'h0);
        sample_stb = 1'b0;
        reset      = 1'b0;
        tick();
        check("rst_idle_busy",   32'(busy),        32'h0);

        // Unity gain and latency
        run_mix("unity", {16'h1111, 16'h2222, 16'h3333, 16'h2000},
                {8'd128, 8'd128, 8'd128, 8'd128}, 4'b1110, 1'b0, 16'h2000);

        // Four-channel sum with inputs changed after the snapshot
        run_mix("sum", {16'h0100, 16'h1000, 16'hE000, 16'h2000},
                {8'd128, 8'd128, 8'd128, 8'd128}, 4'b0000, 1'b1, 16'h1100);

        // Gain, floor rounding and saturation
        run_mix("gain_half", {16'h7777, 16'h5555, 16'h3333, 16'h4000},
                {8'd200, 8'd200, 8'd200, 8'd64}, 4'b1110, 1'b0, 16'h2000);
        run_mix("floor_neg", {16'h7777, 16'h5555, 16'h3333, 16'hFFFF},
                {8'd9, 8'd9, 8'd9, 8'd1}, 4'b1110, 1'b0, 16'hFFFF);
        run_mix("floor_pos", {16'h7777, 16'h5555, 16'h3333, 16'h0001},
                {8'd9, 8'd9, 8'd9, 8'd1}, 4'b1110, 1'b0, 16'h0000);
        run_mix("sat_pos", {4{16'h7000}}, {4{8'd255}}, 4'b0000, 1'b0, 16'h7FFF);
        run_mix("sat_neg", {4{16'h9000}}, {4{8'd255}}, 4'b0000, 1'b0, 16'h8000);

        // Overrun: strobes at edges n and n+2
        ch_data    = {16'h0, 16'h0, 16'h0, 16'h1234};
        ch_vol     = {4{8'd128}};
        ch_mute    = 4'b1110;
        sample_stb = 1'b1;
        tick();                                   // edge n
        sample_stb = 1'b0;
        ch_data    = {16'h0, 16'h0, 16'h0, 16'h0F00};
        tick();                                   // edge n+1
        check("ovr_n1", 32'(overrun), 32'h0);
        sample_stb = 1'b1;
        tick();                                   // edge n+2
        sample_stb = 1'b0;
        check("ovr_n2", 32'(overrun), 32'h0);
        tick();                                   // edge n+3
        check("ovr_n3",     32'(overrun),     32'h1);
        check("ovr_cnt_n3", 32'(overrun_cnt), 32'h1);
        tick();                                   // edge n+4
        check("ovr_n4",       32'(overrun),   32'h0);
        check("ovr_valid_n4", 32'(mix_valid), 32'h0);
        tick();                                   // edge n+5
        check("ovr_valid_n5", 32'(mix_valid), 32'h1);
        check("ovr_out_n5",   32'(mix_out),   32'h1234);
        tick();                                   // edge n+6
        check("ovr_valid_n6", 32'(mix_valid), 32'h0);
        check("ovr_busy_n6",  32'(busy),      32'h0);
        last_mix = 16'h1234;

        // Strobe held high: five drops per six-cycle mix, count saturates
        ch_data    = {16'h0, 16'h0, 16'h0, 16'h0123};
        ch_vol     = {4{8'd128}};
        ch_mute    = 4'b1110;
        held_exp   = model(ch_data, ch_vol, ch_mute);
        sample_stb = 1'b1;
        repeat (12) tick();
        check("ovr_cnt_12", 32'(overrun_cnt), 32'd10);
        repeat (388) tick();
        sample_stb = 1'b0;
        repeat (8) tick();
        check("ovr_cnt_sat",  32'(overrun_cnt), 32'd255);
        check("ovr_quiet",    32'(overrun),     32'h0);
        check("ovr_held_out", 32'(mix_out),     32'(held_exp));
        last_mix = held_exp;

        // Reset in the middle of a mix
        ch_data    = {16'h0, 16'h0, 16'h0, 16'h3000};
        ch_vol     = {4{8'd128}};
        ch_mute    = 4'b1110;
        sample_stb = 1'b1;
        tick();                                   // edge n
        sample_stb = 1'b0;
        tick();                                   // edge n+1
        #3;
        reset      = 1'b1;
        sample_stb = 1'b1;
        #1;
        check("mid_rst_out",   32'(mix_out),     32'h0);
        check("mid_rst_busy",  32'(busy),        32'h0);
        check("mid_rst_cnt",   32'(overrun_cnt), 32'h0);
        check("mid_rst_valid", 32'(mix_valid),   32'h0);
        repeat (2) tick();
        sample_stb = 1'b0;
        reset      = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("mid_rst_novalid", 32'(mix_valid), 32'h0);
            check("mid_rst_hold",    32'(mix_out),   32'h0);
        end
        last_mix = '0;

        run_mix("fresh", {16'h0, 16'h0, 16'h0, 16'h3000},
                {4{8'd128}}, 4'b1110, 1'b0, 16'h3000);

        // Randomized mixes against the reference model
        for (int i = 0; i < 24; i++) begin
            d = {$urandom, $urandom};
            v = $urandom;
            m = 4'($urandom);
            run_mix("rand", d, v, m, 1'($urandom), model(d, v, m));
        end
        check("rand_no_ovr", 32'(overrun_cnt), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
